// File: rtl/inst_fetch_if.sv
// Fetch-control bundle between the test harness/decode side and the PC stage.
// The harness/decode side drives the master modport; the fetch stage takes the slave modport.
interface inst_fetch_if #(
  parameter int A  = 12,
  parameter int CW = 16
);
  logic          start;
  logic [A-1:0]  start_addr;
  logic          halt;
  logic          stall;
  logic          branch_abs;
  logic          branch_rel;
  logic [A-1:0]  target;
  logic [A-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_count;

  modport master (
    output start, start_addr, halt, stall, branch_abs, branch_rel, target,
    input  prog_ctr, running, done, cycle_count
  );

  modport slave (
    input  start, start_addr, halt, stall, branch_abs, branch_rel, target,
    output prog_ctr, running, done, cycle_count
  );
endinterface

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer driving a combinational instruction ROM.
// state | meaning:  IDLE = waiting for launch, RUN = fetching, DONE = halted, awaiting relaunch
module inst_fetch #(
  parameter int A  = 12,
  parameter int CW = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  inst_fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (bus.halt)  state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          pc_d  = bus.start_addr;
          cnt_d = '0;
        end
      end
      RUN: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        // halt and stall both hold the PC; branches only matter when neither is set
        if (bus.halt || bus.stall) pc_d = pc_q;
        else if (bus.branch_abs)   pc_d = bus.target;
        else if (bus.branch_rel)   pc_d = pc_q + bus.target;
        else                       pc_d = pc_q + A'(1);
      end
      default: ;
    endcase
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.cycle_count = cnt_q;
  assign bus.running     = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized check of inst_fetch against an arithmetic reference model.
module tb_inst_fetch;
  localparam int A  = 12;
  localparam int CW = 16;
  localparam int PC_MOD  = 1 << A;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // model: 0 idle, 1 run, 2 done
  int m_state = 0;
  int m_pc    = 0;
  int m_cnt   = 0;

  inst_fetch_if #(.A(A), .CW(CW)) bus ();
  inst_fetch #(.A(A), .CW(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic model_edge(bit st, int sa, bit h, bit s, bit ba, bit br, int t);
    int off;
    if (m_state == 1) begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (h) m_state = 2;
      else if (s) ;
      else if (ba) m_pc = t;
      else if (br) begin
        off  = (t >= PC_MOD / 2) ? t - PC_MOD : t;
        m_pc = (m_pc + off + PC_MOD) % PC_MOD;
      end
      else m_pc = (m_pc + 1) % PC_MOD;
    end else if (st) begin
      m_state = 1; m_pc = sa; m_cnt = 0;
    end
  endtask

  task automatic check(string tag);
    checks += 4;
    assert (bus.prog_ctr === A'(m_pc)) else begin
      errors++; $error("FAIL %s pc observed=%h expected=%h", tag, bus.prog_ctr, m_pc);
    end
    assert (bus.running === (m_state == 1)) else begin
      errors++; $error("FAIL %s running observed=%b expected=%b", tag, bus.running, m_state == 1);
    end
    assert (bus.done === (m_state == 2)) else begin
      errors++; $error("FAIL %s done observed=%b expected=%b", tag, bus.done, m_state == 2);
    end
    assert (bus.cycle_count === CW'(m_cnt)) else begin
      errors++; $error("FAIL %s count observed=%h expected=%h", tag, bus.cycle_count, m_cnt);
    end
  endtask

  task automatic step(bit st, int sa, bit h, bit s, bit ba, bit br, int t, string tag, bit do_check = 1);
    bus.start = st; bus.start_addr = A'(sa); bus.halt = h; bus.stall = s;
    bus.branch_abs = ba; bus.branch_rel = br; bus.target = A'(t);
    @(posedge clk); #1;
    model_edge(st, sa, h, s, ba, br, t);
    if (do_check) check(tag);
  endtask

  task automatic idle_step(string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    bus.start = 0; bus.start_addr = '0; bus.halt = 0; bus.stall = 0;
    bus.branch_abs = 0; bus.branch_rel = 0; bus.target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset");
    @(negedge clk) rst = 1'b0;

    idle_step("idle_hold");
    step(0, 0, 1, 1, 1, 0, 12'h055, "idle_ignores");
    step(1, 12'h000, 0, 0, 0, 0, 0, "start0");
    for (int i = 0; i < 5; i++) idle_step("seq");
    while (m_pc != 12'h010) idle_step("to_010");
    step(0, 0, 0, 0, 1, 0, 12'h123, "babs");
    step(0, 0, 0, 0, 0, 1, 12'hFFD, "brel_neg");
    step(0, 0, 0, 0, 1, 1, 12'h050, "both");
    step(0, 0, 1, 0, 0, 0, 0, "halt1");
    idle_step("done_hold");

    step(1, 12'hFFE, 0, 0, 0, 0, 0, "start_ffe");
    for (int i = 0; i < 3; i++) idle_step("wrap");
    idle_step("to_002");
    step(0, 0, 0, 0, 0, 1, 12'h7FF, "brel_pos_max");
    step(0, 0, 0, 0, 0, 1, 12'h800, "brel_neg_max");

    step(0, 0, 0, 0, 1, 0, 12'h040, "to_040");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, "stall");
    step(0, 0, 1, 1, 0, 0, 0, "halt_stall");
    step(0, 0, 0, 1, 1, 1, 12'h3AB, "done_ignores");
    step(1, 12'h200, 0, 0, 0, 0, 0, "restart");
    step(1, 12'h7A7, 0, 0, 0, 0, 0, "start_in_run");
    idle_step("after_start_in_run");

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, PC_MOD - 1),
           $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, PC_MOD - 1), "rand");

    if (m_state != 1) step(1, 12'h100, 0, 0, 0, 0, 0, "relaunch");
    step(0, 0, 0, 0, 1, 0, 12'h123, "to_123");
    #3 rst = 1'b1;
    #1 model_reset();
    check("async_reset");
    #2 rst = 1'b0;
    idle_step("post_reset_idle");

    step(1, 12'h000, 0, 0, 0, 0, 0, "sat_start");
    for (int i = 0; i < (1 << CW) + 5; i++) step(0, 0, 0, 0, 0, 0, 0, "sat", 1'b0);
    check("saturate");
    checks++;
    assert (bus.cycle_count === 16'hFFFF) else begin
      errors++; $error("FAIL sat_abs observed=%h expected=ffff", bus.cycle_count);
    end
    step(0, 0, 1, 0, 0, 0, 0, "sat_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
